// File: rtl/nios2_mul_seq.sv
// 32x32 multiply sequencer for Nios II MUL/MULX* that time-shares one registered
// 16x16 unsigned multiplier cell over the partial products and corrects the high word for signedness.
module nios2_mul_seq #(
    parameter bit SKIP_HH = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic [15:0] mul_dataa,
    output logic [15:0] mul_datab,
    output logic        mul_ena,
    input  logic [31:0] mul_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [1:0]  k_q;
    logic [1:0]  last_q;
    logic        req_ready_q;
    logic        mul_ena_q;
    logic [15:0] dataa_q;
    logic [15:0] datab_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [31:0] fix_d;

    // Partial product k placed at its weight: LL=0, LH/HL=16, HH=32.
    function automatic logic [63:0] pp_shift(input logic [31:0] p, input logic [1:0] k);
        case (k)
            2'd0:       return {32'd0, p};
            2'd1, 2'd2: return {16'd0, p, 16'd0};
            2'd3:       return {p, 32'd0};
            default:    return 64'd0;
        endcase
    endfunction

    // k[1] picks the high half of A, k[0] the high half of B.
    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] k);
        return {(k[1] ? a[31:16] : a[15:0]), (k[0] ? b[31:16] : b[15:0])};
    endfunction

    // Signed high word = unsigned high word minus the cross terms of negative signed operands.
    function automatic logic [31:0] fix_hi(input logic [1:0] op, input logic [63:0] acc,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi;
        hi = acc[63:32];
        if ((op == 2'b01 || op == 2'b10) && a[31]) begin
            hi = hi - b;
        end else begin
            hi = hi;
        end
        if (op == 2'b01 && b[31]) begin
            hi = hi - a;
        end else begin
            hi = hi;
        end
        return hi;
    endfunction

    // Accumulate the product registered by the cell for the previous issue.
    always_comb begin
        acc_d = acc_q;
        case (state_q)
            S_ISSUE: begin
                if (k_q != 2'd0) begin
                    acc_d = acc_q + pp_shift(mul_result, k_q - 2'd1);
                end else begin
                    acc_d = acc_q;
                end
            end
            S_DRAIN: acc_d = acc_q + pp_shift(mul_result, k_q);
            default: acc_d = acc_q;
        endcase
    end

    // Result word selection for the FIX state.
    always_comb begin
        if (op_q == 2'b00) begin
            fix_d = acc_q[31:0];
        end else begin
            fix_d = fix_hi(op_q, acc_q, src1_q, src2_q);
        end
    end

    // Sequencer FSM with registered handshake and multiplier-cell outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            src1_q      <= 32'd0;
            src2_q      <= 32'd0;
            acc_q       <= 64'd0;
            k_q         <= 2'd0;
            last_q      <= 2'd0;
            req_ready_q <= 1'b0;
            mul_ena_q   <= 1'b0;
            dataa_q     <= 16'd0;
            datab_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        src1_q      <= req_src1;
                        src2_q      <= req_src2;
                        acc_q       <= 64'd0;
                        k_q         <= 2'd0;
                        last_q      <= (req_op == 2'b00 && SKIP_HH) ? 2'd2 : 2'd3;
                        mul_ena_q   <= 1'b1;
                        dataa_q     <= req_src1[15:0];
                        datab_q     <= req_src2[15:0];
                        req_ready_q <= 1'b0;
                        state_q     <= S_ISSUE;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    acc_q <= acc_d;
                    if (k_q == last_q) begin
                        mul_ena_q <= 1'b0;
                        dataa_q   <= 16'd0;
                        datab_q   <= 16'd0;
                        state_q   <= S_DRAIN;
                    end else begin
                        k_q                <= k_q + 2'd1;
                        {dataa_q, datab_q} <= pick(src1_q, src2_q, k_q + 2'd1);
                    end
                end
                S_DRAIN: begin
                    acc_q   <= acc_d;
                    state_q <= S_FIX;
                end
                S_FIX: begin
                    rsp_data_q  <= fix_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b0;
                    mul_ena_q   <= 1'b0;
                    dataa_q     <= 16'd0;
                    datab_q     <= 16'd0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mul_ena   = mul_ena_q;
    assign mul_dataa = dataa_q;
    assign mul_datab = datab_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
